// File: rtl/one_to_n_distributor_if.sv
// Ingress flit stream plus N egress flit slots and error counters of the
// 1-to-N wormhole distributor.
interface one_to_n_distributor_if #(
    parameter int unsigned N         = 6,
    parameter int unsigned FLIT_SIZE = 128
);
    logic [FLIT_SIZE-1:0]   in;
    logic                   in_valid;
    logic                   in_avail;
    logic [FLIT_SIZE*N-1:0] out;
    logic [N-1:0]           out_valid;
    logic [N-1:0]           out_avail;
    logic [15:0]            drop_cnt;
    logic [15:0]            err_cnt;

    // Upstream flit source together with the downstream port consumers
    modport master (
        output in, in_valid, out_avail,
        input  in_avail, out, out_valid, drop_cnt, err_cnt
    );

    // Distributor side
    modport slave (
        input  in, in_valid, out_avail,
        output in_avail, out, out_valid, drop_cnt, err_cnt
    );
endinterface

// File: rtl/one_to_n_distributor.sv
// Wormhole demultiplexer: steers each packet of one flit stream to one of N
// single-flit output slots by the head's destination, holding the route to the tail.
module one_to_n_distributor #(
    parameter int unsigned           N           = 6,
    parameter int unsigned           FLIT_SIZE   = 128,
    parameter int unsigned           HEADER_LEN  = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00,
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10,
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
    parameter int unsigned           DST_POS     = 125,
    parameter int unsigned           DST_LEN     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    one_to_n_distributor_if.slave         bus
);

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [DST_LEN-1:0]          port_q, port_d;
    logic [N-1:0][FLIT_SIZE-1:0] out_q, out_d;
    logic [N-1:0]                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;

    logic [HEADER_LEN-1:0] flit_type;
    logic [DST_LEN-1:0]    dst;
    logic                  dst_ok;
    logic                  is_head;
    logic                  is_body_tail;
    logic                  is_end;
    logic [N-1:0]          slot_free;
    logic                  dst_free;
    logic                  lock_free;
    logic                  in_avail_c;
    logic                  accept;
    logic                  wr_valid;
    logic [DST_LEN-1:0]    wr_port;
    logic                  drop_inc;
    logic                  err_inc;

    assign flit_type    = bus.in[FLIT_SIZE-1 -: HEADER_LEN];
    assign dst          = bus.in[DST_POS -: DST_LEN];
    assign dst_ok       = 32'(dst) < N;
    assign is_head      = (flit_type == HEAD_FLIT);
    assign is_body_tail = (flit_type == BODY_FLIT) || (flit_type == TAIL_FLIT);
    assign is_end       = (flit_type == TAIL_FLIT) || (flit_type == SINGLE_FLIT);

    // A slot can take a flit this edge if it is empty or is being drained now
    assign slot_free = ~out_valid_q | bus.out_avail;

    // Select free flags without indexing out of range for illegal destinations
    always_comb begin : free_sel
        dst_free  = 1'b0;
        lock_free = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(dst) == i) begin
                dst_free = slot_free[i];
            end
            if (32'(port_q) == i) begin
                lock_free = slot_free[i];
            end
        end
    end

    // Ingress back-pressure; flits that will be discarded are always taken
    always_comb begin : avail_logic
        in_avail_c = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: in_avail_c = !bus.in_valid || is_body_tail || !dst_ok || dst_free;
                ST_LOCK: in_avail_c = lock_free;
                ST_DROP: in_avail_c = 1'b1;
                default: in_avail_c = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid && in_avail_c;

    // Route state: decides where an accepted flit goes and which counter moves
    always_comb begin : fsm_next
        state_d  = state_q;
        port_d   = port_q;
        wr_valid = 1'b0;
        wr_port  = port_q;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_body_tail) begin
                        err_inc = 1'b1;
                    end else if (!dst_ok) begin
                        drop_inc = 1'b1;
                        if (is_head) begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        wr_valid = 1'b1;
                        wr_port  = dst;
                        if (is_head) begin
                            state_d = ST_LOCK;
                            port_d  = dst;
                        end
                    end
                end
                ST_LOCK: begin
                    wr_valid = 1'b1;
                    wr_port  = port_q;
                    if (is_end) begin
                        state_d = ST_IDLE;
                    end else if (is_head) begin
                        err_inc = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (is_end) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output slots: a write on the same edge as a drain keeps the slot full
    always_comb begin : slot_next
        out_d       = out_q;
        out_valid_d = out_valid_q & ~bus.out_avail;
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_valid && (32'(wr_port) == i)) begin
                out_d[i]       = bus.in;
                out_valid_d[i] = 1'b1;
            end
        end
    end

    always_comb begin : cnt_next
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (drop_inc && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (err_inc && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q     <= ST_IDLE;
            port_q      <= '0;
            out_q       <= '0;
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.in_avail  = in_avail_c;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_one_to_n_distributor.sv
// Bench for one_to_n_distributor: directed vector table, reset sequence,
// randomized traffic against a packet-level reference model, counter saturation.
module tb_one_to_n_distributor;

    localparam int unsigned N  = 6;
    localparam int unsigned FW = 128;
    localparam logic [1:0] T_H = 2'b00;
    localparam logic [1:0] T_B = 2'b01;
    localparam logic [1:0] T_T = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    typedef struct {
        logic [1:0]    t;
        logic [2:0]    d;
        logic [15:0]   pay;
        logic          vld;
        logic [5:0]    oav;
        logic          e_av;
        logic [5:0]    e_ov;
        int            e_drop;
        int            e_err;
        int            e_port;
        logic [FW-1:0] e_flit;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    one_to_n_distributor_if #(.N(N), .FLIT_SIZE(FW)) bus ();
    one_to_n_distributor #(.N(N), .FLIT_SIZE(FW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [FW*N-1:0] act, input logic [FW*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [2:0] d, input logic [15:0] pay);
        logic [FW-1:0] f;
        f          = '0;
        f[127:126] = t;
        f[125:123] = d;
        f[15:0]    = pay;
        return f;
    endfunction

    function automatic logic [FW-1:0] port_data(input int p);
        return bus.out[p*FW +: FW];
    endfunction

    task automatic row(input logic [1:0] t, input logic [2:0] d, input logic [15:0] pay,
                       input logic vld, input logic [5:0] oav, input logic e_av,
                       input logic [5:0] e_ov, input int e_drop, input int e_err,
                       input int e_port, input logic [FW-1:0] e_flit);
        vec_t v;
        v.t = t; v.d = d; v.pay = pay; v.vld = vld; v.oav = oav;
        v.e_av = e_av; v.e_ov = e_ov; v.e_drop = e_drop; v.e_err = e_err;
        v.e_port = e_port; v.e_flit = e_flit;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_avail = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state: slot contents plus packet-level route bookkeeping
    bit            m_valid[N];
    logic [FW-1:0] m_data[N];
    bit            m_locked;
    bit            m_dropping;
    int            m_port;
    int            m_dropc;
    int            m_errc;

    function automatic bit m_free(input int p, input logic [5:0] oav);
        return !m_valid[p] || oav[p];
    endfunction

    initial begin
        logic [1:0]      t;
        logic [2:0]      d;
        logic            vld;
        logic [5:0]      oav;
        logic [FW-1:0]   f;
        logic [FW*N-1:0] exp_out;
        bit              exp_av;

        // Directed table: one row per cycle, expected in_avail before the edge
        // and out_valid / counters / one port's data after it
        row(T_S, 3, 16'hA5, 1, 6'h3F, 1, 6'h08, 0, 0,  3, mk(T_S, 3, 16'hA5));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 0, 0, -1, '0);
        row(T_H, 1, 16'h11, 1, 6'h3F, 1, 6'h02, 0, 0,  1, mk(T_H, 1, 16'h11));
        row(T_B, 1, 16'h22, 1, 6'h3D, 0, 6'h02, 0, 0,  1, mk(T_H, 1, 16'h11));
        row(T_B, 1, 16'h22, 1, 6'h3D, 0, 6'h02, 0, 0,  1, mk(T_H, 1, 16'h11));
        row(T_B, 1, 16'h22, 1, 6'h3F, 1, 6'h02, 0, 0,  1, mk(T_B, 1, 16'h22));
        row(T_T, 1, 16'h33, 1, 6'h3F, 1, 6'h02, 0, 0,  1, mk(T_T, 1, 16'h33));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 0, 0, -1, '0);
        row(T_H, 2, 16'h41, 1, 6'h3F, 1, 6'h04, 0, 0,  2, mk(T_H, 2, 16'h41));
        row(T_T, 2, 16'h42, 1, 6'h3F, 1, 6'h04, 0, 0,  2, mk(T_T, 2, 16'h42));
        row(T_H, 4, 16'h51, 1, 6'h3F, 1, 6'h10, 0, 0,  4, mk(T_H, 4, 16'h51));
        row(T_T, 0, 16'h52, 1, 6'h3F, 1, 6'h10, 0, 0,  4, mk(T_T, 0, 16'h52));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 0, 0, -1, '0);
        row(T_H, 7, 16'hD1, 1, 6'h3F, 1, 6'h00, 1, 0, -1, '0);
        row(T_B, 1, 16'hD2, 1, 6'h00, 1, 6'h00, 1, 0, -1, '0);
        row(T_B, 1, 16'hD3, 1, 6'h3F, 1, 6'h00, 1, 0, -1, '0);
        row(T_T, 1, 16'hD4, 1, 6'h3F, 1, 6'h00, 1, 0, -1, '0);
        row(T_B, 0, 16'h61, 1, 6'h3F, 1, 6'h00, 1, 1, -1, '0);
        row(T_S, 0, 16'h62, 1, 6'h3F, 1, 6'h01, 1, 1,  0, mk(T_S, 0, 16'h62));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 1, 1, -1, '0);
        row(T_S, 5, 16'h71, 1, 6'h1F, 1, 6'h20, 1, 1,  5, mk(T_S, 5, 16'h71));
        row(T_S, 5, 16'h72, 1, 6'h1F, 0, 6'h20, 1, 1,  5, mk(T_S, 5, 16'h71));
        row(T_S, 5, 16'h72, 1, 6'h3F, 1, 6'h20, 1, 1,  5, mk(T_S, 5, 16'h72));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 1, 1, -1, '0);
        row(T_H, 3, 16'h81, 1, 6'h3F, 1, 6'h08, 1, 1,  3, mk(T_H, 3, 16'h81));
        row(T_H, 0, 16'h82, 1, 6'h3F, 1, 6'h08, 1, 2,  3, mk(T_H, 0, 16'h82));
        row(T_T, 0, 16'h83, 1, 6'h3F, 1, 6'h08, 1, 2,  3, mk(T_T, 0, 16'h83));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 1, 2, -1, '0);
        row(T_S, 6, 16'h91, 1, 6'h3F, 1, 6'h00, 2, 2, -1, '0);
        row(T_S, 2, 16'h92, 1, 6'h3F, 1, 6'h04, 2, 2,  2, mk(T_S, 2, 16'h92));
        row(T_H, 0, 16'h00, 0, 6'h3F, 1, 6'h00, 2, 2, -1, '0);

        rst           = 1'b1;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_avail = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset in_avail", bus.in_avail, 1'b0);
        rst = 1'b0;
        #1;
        check("reset out_valid", bus.out_valid, '0);
        check("reset out", bus.out, '0);
        check("reset drop_cnt", bus.drop_cnt, '0);
        check("reset err_cnt", bus.err_cnt, '0);
        @(negedge clk);

        foreach (tbl[k]) begin
            bus.in        = mk(tbl[k].t, tbl[k].d, tbl[k].pay);
            bus.in_valid  = tbl[k].vld;
            bus.out_avail = tbl[k].oav;
            #1;
            check($sformatf("row%0d in_avail", k), bus.in_avail, tbl[k].e_av);
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", k), bus.out_valid, tbl[k].e_ov);
            check($sformatf("row%0d drop_cnt", k), bus.drop_cnt, tbl[k].e_drop);
            check($sformatf("row%0d err_cnt", k), bus.err_cnt, tbl[k].e_err);
            if (tbl[k].e_port >= 0) begin
                check($sformatf("row%0d port%0d data", k, tbl[k].e_port),
                      port_data(tbl[k].e_port), tbl[k].e_flit);
            end
            @(negedge clk);
        end

        // Reset in the middle of a packet locked to port 0
        bus.out_avail = 6'h3F;
        bus.in        = mk(T_H, 0, 16'hB1);
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in        = mk(T_B, 0, 16'hB2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midpkt rst in_avail", bus.in_avail, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midpkt out_valid", bus.out_valid, '0);
        check("midpkt out", bus.out, '0);
        check("midpkt drop_cnt", bus.drop_cnt, '0);
        check("midpkt err_cnt", bus.err_cnt, '0);
        bus.in = mk(T_S, 5, 16'hB5);
        #1;
        check("midpkt single in_avail", bus.in_avail, 1'b1);
        @(posedge clk);
        #1;
        check("midpkt single out_valid", bus.out_valid, 6'h20);
        check("midpkt single data", port_data(5), mk(T_S, 5, 16'hB5));
        @(negedge clk);
        bus.in = mk(T_T, 0, 16'hB3);
        @(posedge clk);
        #1;
        check("midpkt stale tail err_cnt", bus.err_cnt, 16'd1);
        check("midpkt stale tail out_valid", bus.out_valid, '0);
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        for (int p = 0; p < N; p++) begin
            m_valid[p] = 1'b0;
            m_data[p]  = '0;
        end
        m_locked = 1'b0; m_dropping = 1'b0; m_port = 0; m_dropc = 0; m_errc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            t   = 2'($urandom_range(0, 3));
            d   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            vld = ($urandom_range(0, 3) != 0);
            oav = 6'($urandom);
            f   = mk(t, d, 16'($urandom));
            f[122:16] = {$urandom, $urandom, $urandom, 11'($urandom)};
            bus.in        = f;
            bus.in_valid  = vld;
            bus.out_avail = oav;

            if (m_locked)        exp_av = m_free(m_port, oav);
            else if (m_dropping) exp_av = 1'b1;
            else exp_av = !vld || (t == T_B) || (t == T_T) || (int'(d) >= N) ||
                          ((int'(d) < N) && m_free(int'(d), oav));
            exp_out = '0;
            for (int p = 0; p < N; p++) exp_out[p*FW +: FW] = m_data[p];
            #1;
            check($sformatf("rnd%0d in_avail", cyc), bus.in_avail, exp_av);
            check($sformatf("rnd%0d out_valid", cyc), bus.out_valid,
                  {m_valid[5], m_valid[4], m_valid[3], m_valid[2], m_valid[1], m_valid[0]});
            check($sformatf("rnd%0d out", cyc), bus.out, exp_out);
            check($sformatf("rnd%0d drop_cnt", cyc), bus.drop_cnt, m_dropc);
            check($sformatf("rnd%0d err_cnt", cyc), bus.err_cnt, m_errc);
            @(posedge clk);

            for (int p = 0; p < N; p++) if (m_valid[p] && oav[p]) m_valid[p] = 1'b0;
            if (vld && exp_av) begin
                if (m_locked) begin
                    m_data[m_port]  = f;
                    m_valid[m_port] = 1'b1;
                    if (t == T_H) m_errc = (m_errc < 65535) ? m_errc + 1 : m_errc;
                    if (t == T_T || t == T_S) m_locked = 1'b0;
                end else if (m_dropping) begin
                    if (t == T_T || t == T_S) m_dropping = 1'b0;
                end else if (t == T_B || t == T_T) begin
                    m_errc = (m_errc < 65535) ? m_errc + 1 : m_errc;
                end else if (int'(d) >= N) begin
                    m_dropc = (m_dropc < 65535) ? m_dropc + 1 : m_dropc;
                    if (t == T_H) m_dropping = 1'b1;
                end else begin
                    m_data[d]  = f;
                    m_valid[d] = 1'b1;
                    if (t == T_H) begin
                        m_locked = 1'b1;
                        m_port   = int'(d);
                    end
                end
            end
            @(negedge clk);
        end

        // drop_cnt saturation with back-to-back illegal single flits
        do_reset();
        bus.in        = mk(T_S, 7, 16'hEE);
        bus.in_valid  = 1'b1;
        bus.out_avail = 6'h3F;
        repeat (65534) @(negedge clk);
        check("sat drop_cnt below max", bus.drop_cnt, 16'hFFFE);
        repeat (6) @(negedge clk);
        check("sat drop_cnt held", bus.drop_cnt, 16'hFFFF);
        check("sat err_cnt", bus.err_cnt, '0);
        check("sat out_valid", bus.out_valid, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
